aes_seq_ctrl: RTL
=================

Name: aes_seq_ctrl

Overview:
Sequencer for the AES input-select mux and the AES core behind it. Per job it:
- Steers the mux to the key-schedule words (optional), then to IV+message for block 0, then to chaining ciphertext+message for blocks 1..N-1.
- Pulses the core start and consumes the selected sources via one-cycle acks.
- Counts completed blocks and reports done, abort and error status.

Parameters:
BLK_CNT_W, 16, width of block-count and block-index fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
start_i  in  1  job start request, sampled in IDLE only
nblk_i  in  BLK_CNT_W  number of message blocks in job, captured on start
skip_key_i  in  1  key schedule already loaded; skip KEY phase, captured on start
abort_i  in  1  abandon current job
sel_o  out  2  mux select: 0 key words, 1 IV+msg, 2 chain+msg, 3 none
mux_valid_i  in  1  mux valid for current select
core_start_o  out  1  one-cycle start pulse to AES core
core_done_i  in  1  one-cycle core completion pulse
w_ack_o  out  1  one-cycle consume pulse, key-word source
iv_ack_o  out  1  one-cycle consume pulse, IV source
c_ack_o  out  1  one-cycle consume pulse, chaining-ciphertext source
m_ack_o  out  1  one-cycle consume pulse, message source
busy_o  out  1  job in progress
done_o  out  1  one-cycle job-complete pulse
err_o  out  1  sticky protocol error
blk_idx_o  out  BLK_CNT_W  index of block currently in flight

Behaviour:
- Clocking and reset:
  - Single clock domain. rst_ni low at a clock edge forces the reset state.
  - Reset state: FSM IDLE; sel_o=3; core_start_o, all acks, done_o, busy_o and err_o = 0; blk_idx_o=0; captured nblk=0.
- Registered outputs: all outputs are registered, and sel_o is a function of the registered state.
- FSM states: IDLE, KEY, WAIT_KEY, IV, CHAIN, WAIT_BLK, DONE.
- sel_o by state: KEY=0, IV=1, CHAIN=2; IDLE, WAIT_KEY, WAIT_BLK and DONE drive 3, so mux valid is forced low.
- busy_o=1 in every state except IDLE.
- IDLE:
  - start_i=1 and nblk_i!=0: capture nblk_i and skip_key_i, clear blk_idx and err_o, then go to KEY, or to IV if skip_key_i=1.
  - start_i=1 and nblk_i=0: go to DONE without issuing any core start.
- Accept event: mux_valid_i=1 in an issue state (KEY, IV or CHAIN).
  - In the cycle after acceptance, core_start_o=1 together with that state's acks for exactly one cycle: KEY gives w_ack_o; IV gives iv_ack_o+m_ack_o; CHAIN gives c_ack_o+m_ack_o.
  - The FSM moves to WAIT_KEY from KEY, and to WAIT_BLK from IV or CHAIN. Latency from accept to pulse is 1 cycle.
  - With mux_valid_i=0 the FSM holds in the issue state indefinitely.
- WAIT_KEY: core_done_i moves the FSM to IV.
- WAIT_BLK, on core_done_i:
  - blk_idx+1 == nblk: go to DONE and leave blk_idx unchanged.
  - Otherwise: increment blk_idx and go to CHAIN.
- DONE: done_o=1 for one cycle, then return to IDLE.
- Ignored inputs:
  - start_i while busy_o=1 is ignored.
  - core_done_i in IDLE or DONE is ignored.
- Protocol error: core_done_i in KEY, IV or CHAIN sets err_o and the FSM does not advance. err_o is cleared only by reset or an accepted start.
- abort_i:
  - In any non-IDLE state: IDLE next cycle, no done_o, all pulses suppressed that cycle, blk_idx_o retained for debug.
  - abort_i wins over a simultaneous core_done_i or accept.
  - abort_i in IDLE has no effect.
- Counter range: blk_idx never exceeds nblk-1 and never wraps. nblk max is 2^BLK_CNT_W-1.
- Reset mid-job: immediate return to the reset state. No done_o and no acks are issued.

Decomposition:
- Shared package aes_pkg holds:
  - The select constants SEL_KEY=2'd0, SEL_IV=2'd1, SEL_CHAIN=2'd2, SEL_NONE=2'd3, shared with the mux.
  - The FSM state enum, typedef aes_seq_state_t.
- No sub-module: one FSM plus a block counter in a single module.

Test Plan:
- Job with key: reset, start nblk=3, skip_key=0, mux_valid held 1, core_done 4 cycles after each start.
  - sel sequence 0,3,1,3,2,3,2,3.
  - Exactly 4 core_start pulses.
  - Ack sequence w; iv+m; c+m; c+m.
  - blk_idx 0,1,2.
  - done_o one pulse after the third block's core_done.
- Zero-length job: start nblk=0 -> done_o pulse 2 cycles after start; no core_start or acks; busy_o high 1 cycle.
- Skip key, valid stall: skip_key=1, nblk=1, mux_valid low for 5 cycles.
  - sel_o=1 held for all 5 cycles with no pulses.
  - Single start plus iv_ack+m_ack the cycle after valid rises.
  - done_o after core_done.
- Abort: nblk=4, abort_i asserted in WAIT_BLK with blk_idx=1, same cycle as core_done.
  - IDLE next cycle, done_o never asserted, blk_idx_o=1.
  - A following start_i is accepted.
- Protocol error and sync reset:
  - core_done in CHAIN -> err_o=1 and FSM stays in CHAIN.
  - rst_ni low 1 cycle mid-job -> all outputs at reset values next cycle, err_o=0.
  - start_i during busy -> no effect.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared select codes and sequencer state type for the AES datapath
package aes_pkg;

    localparam logic [1:0] SEL_KEY   = 2'd0;
    localparam logic [1:0] SEL_IV    = 2'd1;
    localparam logic [1:0] SEL_CHAIN = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_WAIT_KEY,
        ST_IV,
        ST_CHAIN,
        ST_WAIT_BLK,
        ST_DONE
    } aes_seq_state_t;

    // Only the issue states open the mux; every other state parks it on NONE.
    function automatic logic [1:0] sel_for_state(input aes_seq_state_t st);
        logic [1:0] sel;
        case (st)
            ST_KEY:   sel = SEL_KEY;
            ST_IV:    sel = SEL_IV;
            ST_CHAIN: sel = SEL_CHAIN;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/aes_seq_ctrl.sv
// rtl/aes_seq_ctrl.sv - AES input-mux and core sequencer with block counter
module aes_seq_ctrl
    import aes_pkg::*;
#(
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [BLK_CNT_W-1:0] nblk_i,
    input  logic                 skip_key_i,
    input  logic                 abort_i,
    output logic [1:0]           sel_o,
    input  logic                 mux_valid_i,
    output logic                 core_start_o,
    input  logic                 core_done_i,
    output logic                 w_ack_o,
    output logic                 iv_ack_o,
    output logic                 c_ack_o,
    output logic                 m_ack_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [BLK_CNT_W-1:0] blk_idx_o
);

    aes_seq_state_t       state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic                 core_start_q, core_start_d;
    logic                 w_ack_q, w_ack_d;
    logic                 iv_ack_q, iv_ack_d;
    logic                 c_ack_q, c_ack_d;
    logic                 m_ack_q, m_ack_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [BLK_CNT_W-1:0] blk_idx_q, blk_idx_d;
    logic [BLK_CNT_W-1:0] nblk_q, nblk_d;
    logic                 last_blk;

    // nblk_q is nonzero whenever a block is in flight, so the subtraction cannot wrap.
    assign last_blk = (blk_idx_q == (nblk_q - BLK_CNT_W'(1)));

    always_comb begin
        state_d      = state_q;
        blk_idx_d    = blk_idx_q;
        nblk_d       = nblk_q;
        err_d        = err_q;
        core_start_d = 1'b0;
        w_ack_d      = 1'b0;
        iv_ack_d     = 1'b0;
        c_ack_d      = 1'b0;
        m_ack_d      = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (nblk_i != '0) begin
                        nblk_d    = nblk_i;
                        blk_idx_d = '0;
                        err_d     = 1'b0;
                        state_d   = skip_key_i ? ST_IV : ST_KEY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_KEY: begin
                if (core_done_i) begin
                    err_d = 1'b1;
                end else if (mux_valid_i) begin
                    core_start_d = 1'b1;
                    w_ack_d      = 1'b1;
                    state_d      = ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                if (core_done_i) begin
                    state_d = ST_IV;
                end
            end
            ST_IV: begin
                if (core_done_i) begin
                    err_d = 1'b1;
                end else if (mux_valid_i) begin
                    core_start_d = 1'b1;
                    iv_ack_d     = 1'b1;
                    m_ack_d      = 1'b1;
                    state_d      = ST_WAIT_BLK;
                end
            end
            ST_CHAIN: begin
                if (core_done_i) begin
                    err_d = 1'b1;
                end else if (mux_valid_i) begin
                    core_start_d = 1'b1;
                    c_ack_d      = 1'b1;
                    m_ack_d      = 1'b1;
                    state_d      = ST_WAIT_BLK;
                end
            end
            ST_WAIT_BLK: begin
                if (core_done_i) begin
                    if (last_blk) begin
                        state_d = ST_DONE;
                    end else begin
                        blk_idx_d = blk_idx_q + BLK_CNT_W'(1);
                        state_d   = ST_CHAIN;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above; blk_idx is kept for post-mortem.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            blk_idx_d    = blk_idx_q;
            nblk_d       = nblk_q;
            err_d        = err_q;
            core_start_d = 1'b0;
            w_ack_d      = 1'b0;
            iv_ack_d     = 1'b0;
            c_ack_d      = 1'b0;
            m_ack_d      = 1'b0;
            done_d       = 1'b0;
        end

        sel_d  = sel_for_state(state_d);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_NONE;
            core_start_q <= 1'b0;
            w_ack_q      <= 1'b0;
            iv_ack_q     <= 1'b0;
            c_ack_q      <= 1'b0;
            m_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            blk_idx_q    <= '0;
            nblk_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            core_start_q <= core_start_d;
            w_ack_q      <= w_ack_d;
            iv_ack_q     <= iv_ack_d;
            c_ack_q      <= c_ack_d;
            m_ack_q      <= m_ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            blk_idx_q    <= blk_idx_d;
            nblk_q       <= nblk_d;
        end
    end

    assign sel_o        = sel_q;
    assign core_start_o = core_start_q;
    assign w_ack_o      = w_ack_q;
    assign iv_ack_o     = iv_ack_q;
    assign c_ack_o      = c_ack_q;
    assign m_ack_o      = m_ack_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign blk_idx_o    = blk_idx_q;

endmodule
